// File: rtl/frogger_pkg.sv
// frogger_pkg: shared game states, water-row geometry and score helpers
package frogger_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    DYING     = 3'd2,
    WIN       = 3'd3,
    GAME_OVER = 3'd4
  } game_state_t;

  localparam int WATER_TOP_Y  = 320;
  localparam int ROW_HEIGHT   = 40;
  localparam int NUM_ROWS     = 4;
  localparam int ROW_W        = 2;
  localparam int GOAL_Y       = 280;
  localparam int SCREEN_W     = 640;
  localparam int START_LIVES  = 3;
  localparam int DEATH_FRAMES = 60;
  localparam int WIN_FRAMES   = 90;
  localparam int CNT_W        = 7;
  localparam int SCORE_MAX    = 9999;

  // Score add that clamps at SCORE_MAX instead of wrapping
  function automatic logic [13:0] sat_add(input logic [13:0] s, input logic [6:0] inc);
    logic [14:0] sum;
    sum = {1'b0, s} + {8'd0, inc};
    return (sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : sum[13:0];
  endfunction
endpackage

// File: rtl/frog_game_state_if.sv
// frog_game_state_if: frog/lilypad inputs and HUD/frog-control outputs of the game-rule stage
interface frog_game_state_if;
  logic                           Start;
  logic [10:0]                    FrogX;
  logic [10:0]                    FrogY;
  logic [10:0]                    Frog_Width;
  logic [frogger_pkg::NUM_ROWS-1:0] LPad_Collision;
  logic                           Frog_Respawn;
  logic                           Freeze_Input;
  logic [1:0]                     Lives;
  logic [13:0]                    Score;
  logic [2:0]                     Game_State;
  logic                           Dead_Flash;

  modport master (
    output Start, FrogX, FrogY, Frog_Width, LPad_Collision,
    input  Frog_Respawn, Freeze_Input, Lives, Score, Game_State, Dead_Flash
  );

  modport slave (
    input  Start, FrogX, FrogY, Frog_Width, LPad_Collision,
    output Frog_Respawn, Freeze_Input, Lives, Score, Game_State, Dead_Flash
  );
endinterface

// File: rtl/water_row_decode.sv
// water_row_decode: maps frog Y to water membership and row index (row 0 topmost)
module water_row_decode
  import frogger_pkg::*;
(
  input  logic [10:0]      y,
  output logic             in_water,
  output logic [ROW_W-1:0] row
);
  assign in_water = (y >= 11'(WATER_TOP_Y)) && (y < 11'(WATER_TOP_Y + NUM_ROWS * ROW_HEIGHT));
  // Comparator chain against each row's top edge; avoids a divider
  always_comb begin
    row = '0;
    for (int k = 1; k < NUM_ROWS; k++)
      if (y >= 11'(WATER_TOP_Y + k * ROW_HEIGHT)) row = ROW_W'(k);
  end
endmodule

// File: rtl/frog_game_state.sv
// frog_game_state: per-frame game rules, lives/score bookkeeping and respawn control
module frog_game_state
  import frogger_pkg::*;
(
  input logic               frame_clk,
  input logic               Reset,
  frog_game_state_if.slave  bus
);
  game_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [ROW_W:0]   best_row;
  logic             in_water;
  logic [ROW_W-1:0] row;
  logic             drown;
  logic             oob;

  water_row_decode u_dec (
    .y        (bus.FrogY),
    .in_water (in_water),
    .row      (row)
  );

  assign drown = in_water && !bus.LPad_Collision[row];
  assign oob = in_water && (bus.FrogX[10] || (({1'b0, bus.FrogX} + {1'b0, bus.Frog_Width}) > 12'(SCREEN_W)));
  assign bus.Game_State = state;

  // Game FSM; every output is registered and the frame counter clears on each state entry
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state            <= IDLE;
      bus.Lives        <= 2'(START_LIVES);
      bus.Score        <= '0;
      bus.Frog_Respawn <= 1'b0;
      bus.Freeze_Input <= 1'b1;
      bus.Dead_Flash   <= 1'b0;
      cnt              <= '0;
      best_row         <= (ROW_W+1)'(NUM_ROWS);
    end else begin
      bus.Frog_Respawn <= 1'b0;
      cnt              <= cnt + 1'b1;
      case (state)
        IDLE, GAME_OVER: if (bus.Start) begin
          state            <= PLAY;
          bus.Lives        <= 2'(START_LIVES);
          bus.Score        <= '0;
          best_row         <= (ROW_W+1)'(NUM_ROWS);
          bus.Frog_Respawn <= 1'b1;
          bus.Freeze_Input <= 1'b0;
          cnt              <= '0;
        end
        PLAY: if (bus.FrogY < 11'(GOAL_Y)) begin
          state            <= WIN;
          bus.Score        <= sat_add(bus.Score, 7'd100);
          bus.Freeze_Input <= 1'b1;
          cnt              <= '0;
        end else if (drown || oob) begin
          state            <= DYING;
          bus.Freeze_Input <= 1'b1;
          cnt              <= '0;
        end else if (in_water && ({1'b0, row} < best_row)) begin
          bus.Score <= sat_add(bus.Score, 7'd10);
          best_row  <= {1'b0, row};
        end
        DYING: if (cnt == CNT_W'(DEATH_FRAMES - 1)) begin
          bus.Lives      <= (bus.Lives == 2'd0) ? 2'd0 : bus.Lives - 2'd1;
          bus.Dead_Flash <= 1'b0;
          cnt            <= '0;
          if (bus.Lives <= 2'd1) state <= GAME_OVER;
          else begin
            state            <= PLAY;
            bus.Frog_Respawn <= 1'b1;
            bus.Freeze_Input <= 1'b0;
            best_row         <= (ROW_W+1)'(NUM_ROWS);
          end
        end else if (cnt[2:0] == 3'd7) bus.Dead_Flash <= ~bus.Dead_Flash;
        WIN: if (cnt == CNT_W'(WIN_FRAMES - 1)) begin
          state            <= PLAY;
          bus.Frog_Respawn <= 1'b1;
          bus.Freeze_Input <= 1'b0;
          best_row         <= (ROW_W+1)'(NUM_ROWS);
          cnt              <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frog_game_state.sv
// tb_frog_game_state: directed frames with a scoreboard queue checked by a separate monitor
module tb_frog_game_state;
  typedef struct {
    int          at;
    string       name;
    logic [2:0]  st;
    logic [1:0]  lives;
    logic [13:0] score;
    logic        resp;
    logic        frz;
    logic        flash;
  } exp_t;

  logic frame_clk;
  logic Reset;
  int   cyc;
  int   tests;
  int   failed;
  int   sc;
  exp_t q[$];

  frog_game_state_if bus ();

  frog_game_state dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  always @(posedge frame_clk) cyc <= cyc + 1;

  // Monitor: pop every expectation whose frame has been clocked and compare
  always @(negedge frame_clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      tests++;
      if (bus.Game_State !== e.st || bus.Lives !== e.lives || bus.Score !== e.score ||
          bus.Frog_Respawn !== e.resp || bus.Freeze_Input !== e.frz || bus.Dead_Flash !== e.flash) begin
        failed++;
        $display("FAIL %s: got st=%0d lives=%0d score=%0d resp=%0b frz=%0b flash=%0b, expected st=%0d lives=%0d score=%0d resp=%0b frz=%0b flash=%0b",
                 e.name, bus.Game_State, bus.Lives, bus.Score, bus.Frog_Respawn, bus.Freeze_Input, bus.Dead_Flash,
                 e.st, e.lives, e.score, e.resp, e.frz, e.flash);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, tests=%0d failed=%0d", tests, failed);
    $fatal(1);
  end

  task automatic push(input int at, input string n, input int s, input int l, input int scr,
                      input logic r, input logic f, input logic fl);
    exp_t e;
    e.at = at; e.name = n; e.st = 3'(s); e.lives = 2'(l); e.score = 14'(scr);
    e.resp = r; e.frz = f; e.flash = fl;
    q.push_back(e);
  endtask

  task automatic expect_next(input string n, input int s, input int l, input int scr,
                             input logic r, input logic f, input logic fl);
    push(cyc + 1, n, s, l, scr, r, f, fl);
  endtask

  task automatic frame(input logic st, input int y, input logic [3:0] lp, input int x = 300, input int w = 20);
    bus.Start = st;
    bus.FrogY = 11'(y);
    bus.FrogX = 11'(x);
    bus.Frog_Width = 11'(w);
    bus.LPad_Collision = lp;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic die(input int lives_before, input int scr);
    expect_next("enter_dying", 2, lives_before, scr, 0, 1, 0);
    frame(0, 410, 4'b0000);
    for (int j = 1; j < 60; j++) begin
      expect_next("dying_flash", 2, lives_before, scr, 0, 1, 1'((j >> 3) & 1));
      frame(0, 410, 4'b0000);
    end
    if (lives_before == 1) expect_next("to_game_over", 4, 0, scr, 0, 1, 0);
    else expect_next("death_respawn", 1, lives_before - 1, scr, 1, 0, 0);
    frame(0, 500, 4'b0000);
  endtask

  task automatic win_round(input int scr);
    expect_next("enter_win", 3, 3, scr, 0, 1, 0);
    frame(0, 250, 4'b0000);
    for (int j = 1; j < 90; j++) begin
      if (j == 1 || j == 89) expect_next("win_hold", 3, 3, scr, 0, 1, 0);
      frame(0, 250, 4'b0000);
    end
    expect_next("win_respawn", 1, 3, scr, 1, 0, 0);
    frame(0, 500, 4'b0000);
  endtask

  initial begin
    cyc = 0; tests = 0; failed = 0;
    Reset = 1'b0;
    bus.Start = 1'b0; bus.FrogX = 11'd300; bus.FrogY = 11'd500;
    bus.Frog_Width = 11'd20; bus.LPad_Collision = 4'b0000;
    #1;
    push(cyc, "reset_state", 0, 3, 0, 0, 1, 0);
    repeat (2) @(posedge frame_clk);
    #1;
    Reset = 1'b1;
    expect_next("idle_hold", 0, 3, 0, 0, 1, 0);
    frame(0, 500, 4'b0000);
    expect_next("start_respawn", 1, 3, 0, 1, 0, 0);
    frame(1, 500, 4'b0000);
    expect_next("pulse_one_frame", 1, 3, 0, 0, 0, 0);
    frame(0, 500, 4'b0000);
    expect_next("start_ignored_play", 1, 3, 0, 0, 0, 0);
    frame(1, 500, 4'b0000);
    expect_next("row0_score", 1, 3, 10, 0, 0, 0);
    frame(0, 330, 4'b0001);
    expect_next("row1_no_gain", 1, 3, 10, 0, 0, 0);
    frame(0, 370, 4'b0010);
    die(3, 10);
    expect_next("after_respawn", 1, 2, 10, 0, 0, 0);
    frame(0, 500, 4'b0000);
    expect_next("best_row_reset", 1, 2, 20, 0, 0, 0);
    frame(0, 330, 4'b0001);
    die(2, 20);
    die(1, 20);
    expect_next("game_over_hold", 4, 0, 20, 0, 1, 0);
    frame(0, 500, 4'b0000);
    expect_next("new_game", 1, 3, 0, 1, 0, 0);
    frame(1, 500, 4'b0000);
    expect_next("oob_dying", 2, 3, 0, 0, 1, 0);
    frame(0, 330, 4'b0001, 630, 20);
    repeat (5) frame(0, 330, 4'b0001, 630, 20);
    Reset = 1'b0;
    push(cyc, "reset_mid_dying", 0, 3, 0, 0, 1, 0);
    @(posedge frame_clk);
    #1;
    push(cyc, "reset_no_pulse", 0, 3, 0, 0, 1, 0);
    Reset = 1'b1;
    expect_next("restart", 1, 3, 0, 1, 0, 0);
    frame(1, 500, 4'b0000);
    expect_next("lpad_ignored_on_land", 1, 3, 0, 0, 0, 0);
    frame(0, 300, 4'b0000);
    win_round(100);
    sc = 100;
    for (int n = 1; n <= 72; n++) begin
      for (int r = 3; r >= 0; r--) begin
        sc = (sc + 10 > 9999) ? 9999 : sc + 10;
        expect_next("row_climb", 1, 3, sc, 0, 0, 0);
        frame(0, 330 + 40 * r, 4'b1111);
      end
      sc = (sc + 100 > 9999) ? 9999 : sc + 100;
      win_round(sc);
    end
    expect_next("score_saturated", 1, 3, 9999, 0, 0, 0);
    frame(0, 470, 4'b1111);
    repeat (2) @(negedge frame_clk);
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
